memtest_walk_seq: RTL and testbench

- Walking-ones memory test sequencer for the memTest device.
- For every address from 0 to a programmed end address, it writes each one-hot pattern, reads it back, and checks the result.
- It sits directly upstream of the comparator stage: it drives comparator operands (read data, expected pattern) and consumes the comparator's equality result to decide pass/fail.

---
 rtl/memtest_walk_seq.sv | 181 ++++++++++++++++++
 tb/tb_memtest_walk_seq.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/memtest_walk_seq.sv
// Walking-ones memory test sequencer.
// For each address from 0 to the latched end address, every one-hot pattern
// is written, read back one cycle later, and checked through an external
// comparator. The first mismatch ends the run and is captured.
//
//   state   | meaning
//   --------+----------------------------------------------------------
//   S_IDLE  | waiting for i_START after reset
//   S_WRITE | write current one-hot pattern to current address
//   S_READ  | issue read of current address
//   S_CHECK | read data valid; sample comparator result
//   S_DONE  | run finished; o_DONE/o_PASS held until next i_START
module memtest_walk_seq #(
    parameter int p_DATA_WIDTH = 8,
    parameter int p_ADDR_WIDTH = 8
) (
    input  logic                    i_CLK,
    input  logic                    i_RST_N,
    input  logic                    i_START,
    input  logic [p_ADDR_WIDTH-1:0] i_ADDR_END,
    output logic [p_ADDR_WIDTH-1:0] o_MEM_ADDR,
    output logic [p_DATA_WIDTH-1:0] o_MEM_WDATA,
    output logic                    o_MEM_WE,
    output logic                    o_MEM_RE,
    input  logic [p_DATA_WIDTH-1:0] i_MEM_RDATA,
    output logic [p_DATA_WIDTH-1:0] o_CMP_DIN0,
    input  logic                    i_CMP_EQUAL,
    output logic [p_DATA_WIDTH-1:0] o_CMP_DIN1,
    output logic                    o_BUSY,
    output logic                    o_DONE,
    output logic                    o_PASS,
    output logic [p_ADDR_WIDTH-1:0] o_FAIL_ADDR,
    output logic [p_DATA_WIDTH-1:0] o_FAIL_DATA
);

    localparam int c_BIT_W = (p_DATA_WIDTH > 1) ? $clog2(p_DATA_WIDTH) : 1;
    localparam logic [c_BIT_W-1:0]      c_BIT_LAST  = c_BIT_W'(p_DATA_WIDTH - 1);
    localparam logic [c_BIT_W-1:0]      c_BIT_ONE   = c_BIT_W'(1);
    localparam logic [p_ADDR_WIDTH-1:0] c_ADDR_ONE  = p_ADDR_WIDTH'(1);
    localparam logic [p_DATA_WIDTH-1:0] c_PAT_FIRST = p_DATA_WIDTH'(1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WRITE = 3'd1,
        S_READ  = 3'd2,
        S_CHECK = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;

    logic [p_ADDR_WIDTH-1:0] r_addr;
    logic [p_ADDR_WIDTH-1:0] r_addr_end;
    logic [c_BIT_W-1:0]      r_bit;
    logic [p_DATA_WIDTH-1:0] r_pattern;
    logic                    r_done;
    logic                    r_pass;
    logic [p_ADDR_WIDTH-1:0] r_fail_addr;
    logic [p_DATA_WIDTH-1:0] r_fail_data;

    logic                    w_mem_we;
    logic                    w_mem_re;
    logic                    w_busy;
    logic                    w_accept;
    logic                    w_fail;
    logic                    w_next_bit;
    logic                    w_next_addr;
    logic                    w_pass_set;

    // State register; reset aborts any run immediately.
    always_ff @(posedge i_CLK or negedge i_RST_N) begin
        if (!i_RST_N) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode and per-state strobes.
    always_comb begin
        w_state_nxt = r_state;
        w_mem_we    = 1'b0;
        w_mem_re    = 1'b0;
        w_busy      = 1'b0;
        w_accept    = 1'b0;
        w_fail      = 1'b0;
        w_next_bit  = 1'b0;
        w_next_addr = 1'b0;
        w_pass_set  = 1'b0;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (i_START) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_WRITE;
                end
            end
            S_WRITE: begin
                w_mem_we    = 1'b1;
                w_busy      = 1'b1;
                w_state_nxt = S_READ;
            end
            S_READ: begin
                w_mem_re    = 1'b1;
                w_busy      = 1'b1;
                w_state_nxt = S_CHECK;
            end
            S_CHECK: begin
                w_busy = 1'b1;
                if (!i_CMP_EQUAL) begin
                    w_fail      = 1'b1;
                    w_state_nxt = S_DONE;
                end else if (r_bit != c_BIT_LAST) begin
                    w_next_bit  = 1'b1;
                    w_state_nxt = S_WRITE;
                end else if (r_addr != r_addr_end) begin
                    // Compare before increment so an all-ones end never wraps.
                    w_next_addr = 1'b1;
                    w_state_nxt = S_WRITE;
                end else begin
                    w_pass_set  = 1'b1;
                    w_state_nxt = S_DONE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Address/pattern walk plus sticky result and first-failure capture.
    always_ff @(posedge i_CLK or negedge i_RST_N) begin
        if (!i_RST_N) begin
            r_addr      <= '0;
            r_addr_end  <= '0;
            r_bit       <= '0;
            r_pattern   <= '0;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
            r_fail_addr <= '0;
            r_fail_data <= '0;
        end else if (w_accept) begin
            r_addr_end  <= i_ADDR_END;
            r_addr      <= '0;
            r_bit       <= '0;
            r_pattern   <= c_PAT_FIRST;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
            r_fail_addr <= '0;
            r_fail_data <= '0;
        end else if (w_fail) begin
            r_fail_addr <= r_addr;
            r_fail_data <= i_MEM_RDATA;
            r_done      <= 1'b1;
            r_pass      <= 1'b0;
        end else if (w_next_bit) begin
            r_bit     <= r_bit + c_BIT_ONE;
            r_pattern <= r_pattern << 1;
        end else if (w_next_addr) begin
            r_addr    <= r_addr + c_ADDR_ONE;
            r_bit     <= '0;
            r_pattern <= c_PAT_FIRST;
        end else if (w_pass_set) begin
            r_done <= 1'b1;
            r_pass <= 1'b1;
        end
    end

    assign o_MEM_ADDR  = r_addr;
    assign o_MEM_WDATA = w_mem_we ? r_pattern : '0;
    assign o_MEM_WE    = w_mem_we;
    assign o_MEM_RE    = w_mem_re;
    assign o_CMP_DIN0  = i_MEM_RDATA;
    assign o_CMP_DIN1  = r_pattern;
    assign o_BUSY      = w_busy;
    assign o_DONE      = r_done;
    assign o_PASS      = r_pass;
    assign o_FAIL_ADDR = r_fail_addr;
    assign o_FAIL_DATA = r_fail_data;

endmodule

// File: tb/tb_memtest_walk_seq.sv
// Directed bench for memtest_walk_seq with a behavioural memory (optional
// stuck-at-0 on bit 3 of address 5) and an ideal equality comparator.
module tb_memtest_walk_seq;

    localparam int DW = 8;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [AW-1:0] addr_end;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] wdata;
    logic          we;
    logic          re;
    logic [DW-1:0] rdata = '0;
    logic [DW-1:0] din0;
    logic          cmp_equal;
    logic [DW-1:0] din1;
    logic          busy;
    logic          done;
    logic          pass;
    logic [AW-1:0] fail_addr;
    logic [DW-1:0] fail_data;

    int n_vec = 0;
    int n_err = 0;

    memtest_walk_seq #(.p_DATA_WIDTH(DW), .p_ADDR_WIDTH(AW)) dut (
        .i_CLK       (clk),
        .i_RST_N     (rst_n),
        .i_START     (start),
        .i_ADDR_END  (addr_end),
        .o_MEM_ADDR  (mem_addr),
        .o_MEM_WDATA (wdata),
        .o_MEM_WE    (we),
        .o_MEM_RE    (re),
        .i_MEM_RDATA (rdata),
        .o_CMP_DIN0  (din0),
        .i_CMP_EQUAL (cmp_equal),
        .o_CMP_DIN1  (din1),
        .o_BUSY      (busy),
        .o_DONE      (done),
        .o_PASS      (pass),
        .o_FAIL_ADDR (fail_addr),
        .o_FAIL_DATA (fail_data)
    );

    always #5 clk = ~clk;

    assign cmp_equal = (din0 == din1);

    logic [DW-1:0] mem [0:15];
    bit            fault_en = 1'b0;

    always @(posedge clk) begin
        if (we) mem[mem_addr] <= (fault_en && mem_addr == AW'(5)) ? (wdata & 8'hF7) : wdata;
        if (re) rdata <= mem[mem_addr];
    end

    // Protocol monitor: expected write order is addr = n/8, data = 1 << (n%8).
    int            wr_count   = 0;
    int            seq_err    = 0;
    int            strobe_cnt = 0;
    logic [AW-1:0] last_wr_addr = '0;
    logic [DW-1:0] last_wr_data = '0;

    always @(posedge clk) begin
        if (rst_n === 1'b1) begin
            if (we || re) strobe_cnt++;
            if (we && re) seq_err++;
            if (we) begin
                if (wdata !== (DW'(1) << (wr_count % DW)) ||
                    mem_addr !== AW'(wr_count / DW) || din1 !== wdata) seq_err++;
                last_wr_addr = mem_addr;
                last_wr_data = wdata;
                wr_count++;
            end
            if (re && (mem_addr !== last_wr_addr || din1 !== last_wr_data)) seq_err++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Starts a run from a negedge; optional ignored start pulses at cycles
    // glitch and glitch+17. f0 = {done,pass,busy} and fa0 = fail addr on
    // the first cycle after the start is accepted.
    task automatic run(input logic [AW-1:0] e, input int glitch,
                       output int busy_cyc, output logic [2:0] f0, output logic [AW-1:0] fa0);
        wr_count = 0;
        seq_err  = 0;
        busy_cyc = 0;
        start    = 1'b1;
        addr_end = e;
        @(negedge clk);
        start = 1'b0;
        f0  = {done, pass, busy};
        fa0 = fail_addr;
        for (int i = 0; i < 1000; i++) begin
            if (done) break;
            if (busy) busy_cyc++;
            start = (glitch != 0) && (i == glitch || i == glitch + 17);
            if (start) addr_end = '1;
            @(negedge clk);
        end
        start = 1'b0;
        chk("run_done", done, 1);
    endtask

    int            bc;
    int            s0;
    logic [2:0]    f0;
    logic [AW-1:0] fa0;

    initial begin
        rst_n    = 1'b0;
        start    = 1'b0;
        addr_end = '0;

        // Reset with random inputs
        repeat (4) begin
            @(negedge clk);
            start    = 1'($urandom_range(0, 1));
            addr_end = AW'($urandom_range(0, 15));
        end
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_pass", pass, 0);
        chk("rst_we", we, 0);
        chk("rst_re", re, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_wdata", wdata, 0);
        chk("rst_din1", din1, 0);
        chk("rst_fail_addr", fail_addr, 0);
        chk("rst_fail_data", fail_data, 0);
        chk("rst_din0_pass", din0, rdata);
        @(negedge clk);
        start = 1'b0;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_busy", busy, 0);
        chk("idle_strobes", {we, re}, 0);

        // Single address
        run(4'd0, 0, bc, f0, fa0);
        chk("single_first", f0, 3'b001);
        chk("single_busy", bc, 24);
        chk("single_pass", pass, 1);
        chk("single_writes", wr_count, 8);
        chk("single_last_data", last_wr_data, 8'h80);
        chk("single_seq", seq_err, 0);

        // Full range, end = all-ones
        run(4'd15, 0, bc, f0, fa0);
        chk("full_busy", bc, 384);
        chk("full_pass", pass, 1);
        chk("full_writes", wr_count, 128);
        chk("full_last_addr", last_wr_addr, 15);
        chk("full_last_data", last_wr_data, 8'h80);
        chk("full_addr_hold", mem_addr, 15);
        chk("full_seq", seq_err, 0);

        // Start pulses during run are ignored
        run(4'd1, 10, bc, f0, fa0);
        chk("glitch_busy", bc, 48);
        chk("glitch_pass", pass, 1);
        chk("glitch_writes", wr_count, 16);

        // Stuck-at-0 on bit 3 of address 5
        fault_en = 1'b1;
        run(4'd15, 0, bc, f0, fa0);
        chk("fault_pass", pass, 0);
        chk("fault_addr", fail_addr, 5);
        chk("fault_data", fail_data, 8'h00);
        chk("fault_busy", bc, 132);
        chk("fault_writes", wr_count, 44);
        s0 = strobe_cnt;
        repeat (5) @(negedge clk);
        chk("fault_no_strobes", strobe_cnt, s0);
        chk("fault_done_held", {done, pass, busy}, 3'b100);

        // Restart from DONE with a new end address
        fault_en = 1'b0;
        run(4'd2, 0, bc, f0, fa0);
        chk("restart_first", f0, 3'b001);
        chk("restart_fail_clr", fa0, 0);
        chk("restart_busy", bc, 72);
        chk("restart_pass", pass, 1);
        chk("restart_seq", seq_err, 0);

        // Reset mid-run
        start    = 1'b1;
        addr_end = 4'd15;
        @(negedge clk);
        start = 1'b0;
        repeat (49) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_strobes", {we, re}, 0);
        chk("abort_addr", mem_addr, 0);
        chk("abort_din1", din1, 0);
        chk("abort_flags", {done, pass}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run(4'd0, 0, bc, f0, fa0);
        chk("post_abort_busy", bc, 24);
        chk("post_abort_pass", pass, 1);
        chk("post_abort_seq", seq_err, 0);
        chk("post_abort_writes", wr_count, 8);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
